// File: rtl/vx_elastic_fifo.sv
// rtl/vx_elastic_fifo.sv - elastic valid/ready FIFO with flush, occupancy and almost-full/empty flags
//
// Purpose: decouples two valid/ready stages. It exposes the live occupancy and
// programmable almost-full/almost-empty flags, so upstream logic can throttle
// before the FIFO is completely full.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      synchronous, active-high; discards all contents
//   flush      synchronous discard of all contents
//   valid_in   upstream has data            ready_in  FIFO accepts this cycle
//   data_in    input payload
//   valid_out  data_out holds a valid entry ready_out downstream accepts
//   data_out   head entry
//   size       current occupancy
//   alm_full   occupancy >= ALM_FULL       alm_empty occupancy <= ALM_EMPTY
module vx_elastic_fifo #(
    parameter int DATAW     = 1,
    parameter int SIZE      = 4,
    parameter int OUT_REG   = 0,
    parameter int ALM_FULL  = SIZE - 1,
    parameter int ALM_EMPTY = 1,
    localparam int SZW      = (SIZE == 0) ? 1 : $clog2(SIZE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [DATAW-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [DATAW-1:0] data_out,
    output logic [SZW-1:0]   size,
    output logic             alm_full,
    output logic             alm_empty
);

    if (SIZE == 0) begin : g_wire
        assign valid_out = valid_in;
        assign data_out  = data_in;
        assign ready_in  = ready_out & ~flush;
        assign size      = '0;
        assign alm_full  = 1'b0;
        assign alm_empty = 1'b1;
    end else begin : g_fifo
        if (SIZE < 2 || (SIZE & (SIZE - 1)) != 0) begin : g_bad_size
            $error("vx_elastic_fifo: SIZE must be 0 or a power of two >= 2");
        end
        if (ALM_FULL < 1 || ALM_FULL > SIZE) begin : g_bad_alm_full
            $error("vx_elastic_fifo: ALM_FULL must lie in 1..SIZE");
        end
        if (ALM_EMPTY < 0 || ALM_EMPTY > SIZE - 1) begin : g_bad_alm_empty
            $error("vx_elastic_fifo: ALM_EMPTY must lie in 0..SIZE-1");
        end

        localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
        localparam logic [SZW-1:0] FULL_CNT = SZW'(SIZE);
        localparam logic [SZW-1:0] ONE_CNT  = SZW'(1);
        localparam logic [SZW-1:0] AF_CNT   = SZW'(ALM_FULL);
        localparam logic [SZW-1:0] AE_CNT   = SZW'(ALM_EMPTY);

        logic [DATAW-1:0] mem_q [SIZE];
        logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [SZW-1:0]   count_q, count_d;
        logic             full, empty, push, pop;
        logic             mem_we, rd_adv;

        assign full      = (count_q == FULL_CNT);
        assign empty     = (count_q == '0);
        // Independent of ready_out: a full FIFO never takes a word on the
        // strength of a simultaneous pop.
        assign ready_in  = ~full & ~flush & ~reset;
        assign valid_out = ~empty;
        assign push      = valid_in & ready_in;
        assign pop       = valid_out & ready_out;

        assign size      = count_q;
        assign alm_full  = (count_q >= AF_CNT);
        assign alm_empty = (count_q <= AE_CNT);

        if (OUT_REG != 0) begin : g_out_reg
            // The head lives in head_q; the array holds only the entries
            // behind it, so array occupancy is count_q - 1 and it never fills.
            logic [DATAW-1:0] head_q;
            logic             head_load, refill;

            assign head_load = push & (empty | ((count_q == ONE_CNT) & pop));
            assign refill    = pop & (count_q > ONE_CNT);
            assign mem_we    = push & ~head_load;
            assign rd_adv    = refill;
            assign data_out  = head_q;

            always_ff @(posedge clk) begin
                if (head_load) begin
                    head_q <= data_in;
                end else if (refill) begin
                    head_q <= mem_q[rd_ptr_q];
                end
            end
        end else begin : g_out_mux
            assign mem_we   = push;
            assign rd_adv   = pop;
            assign data_out = mem_q[rd_ptr_q];
        end

        always_comb begin
            count_d  = count_q;
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            if (push && !pop) begin
                count_d = count_q + ONE_CNT;
            end else if (pop && !push) begin
                count_d = count_q - ONE_CNT;
            end
            if (rd_adv) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (mem_we) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            // Flush wins over any push or pop in the same cycle.
            if (flush) begin
                count_d  = '0;
                rd_ptr_d = '0;
                wr_ptr_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                count_q  <= count_d;
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
            end
        end

        always_ff @(posedge clk) begin
            if (mem_we) begin
                mem_q[wr_ptr_q] <= data_in;
            end
        end
    end

endmodule
